// File: rtl/icache_block_responder_pkg.sv
// Shared types for the instruction-fetch block responder: FSM states,
// block sizing and counter/address types.
package icache_block_responder_pkg;

  localparam int ICACHE_BLOCK_BYTES     = 16;
  localparam int ICACHE_INST_BLOCK_SIZE = 8 * ICACHE_BLOCK_BYTES;

  typedef logic [4:0]  block_cnt_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/icache_block_responder.sv
// Memory-controller side of the instruction-fetch port: fetches one icache block
// byte-by-byte over the RAM bus and hands the assembled block back to the fetcher.
module icache_block_responder
  import icache_block_responder_pkg::*;
#(
  parameter int BLOCK_BYTES = ICACHE_BLOCK_BYTES,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       enable_sign_from_fetcher,
  input  logic [ADDR_WIDTH-1:0]      pc_from_fetcher,
  input  logic                       rollback_sign_from_fetcher,
  output logic                       finish_sign_to_fetcher,
  output logic [8*BLOCK_BYTES-1:0]   inst_block_to_fetcher,
  output logic                       bus_req_to_arbiter,
  input  logic                       bus_grant_from_arbiter,
  output logic [ADDR_WIDTH-1:0]      mem_a_to_ram,
  input  logic [7:0]                 mem_din_from_ram,
  output logic                       mem_wr_to_ram
);

  localparam int         LANE_W   = $clog2(BLOCK_BYTES);
  localparam block_cnt_t CNT_FULL = block_cnt_t'(BLOCK_BYTES);
  localparam block_cnt_t CNT_LAST = block_cnt_t'(BLOCK_BYTES - 1);

  state_t                   state, state_nxt;
  block_cnt_t               issue_cnt, recv_cnt;
  logic                     inflight;
  logic [ADDR_WIDTH-1:0]    base;
  logic [8*BLOCK_BYTES-1:0] block_buf;
  logic [8*BLOCK_BYTES-1:0] assembled;
  logic [LANE_W+2:0]        lane_lsb;

  logic issue, capture, capture_last, abort, start;

  // Rollback only takes effect while the pipeline is running.
  assign abort        = rdy && rollback_sign_from_fetcher;
  assign start        = (state == ST_IDLE) && rdy && enable_sign_from_fetcher && !rollback_sign_from_fetcher;
  // RAM latency is fixed, so capture runs even when rdy is low.
  assign capture      = (state == ST_READ) && inflight;
  assign capture_last = capture && (recv_cnt == CNT_LAST);
  assign lane_lsb     = {recv_cnt[LANE_W-1:0], 3'b000};
  assign mem_wr_to_ram = 1'b0;

  always_comb begin
    assembled = block_buf;
    assembled[lane_lsb +: 8] = mem_din_from_ram;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)        state_nxt = ST_READ;
      ST_READ: if (capture_last) state_nxt = ST_DONE;
      ST_DONE: if (rdy)          state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    bus_req_to_arbiter = (state == ST_READ) && (issue_cnt < CNT_FULL);
    issue              = bus_req_to_arbiter && bus_grant_from_arbiter && rdy;
    mem_a_to_ram       = '0;
    if (issue) mem_a_to_ram = base + ADDR_WIDTH'(issue_cnt);
  end

  // Control: issue/receive counters and the one-deep in-flight flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inflight  <= 1'b0;
    end else if (abort) begin
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (start) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (issue)   issue_cnt <= issue_cnt + block_cnt_t'(1);
        if (capture) recv_cnt  <= recv_cnt + block_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start)   base      <= pc_from_fetcher & ~ADDR_WIDTH'(BLOCK_BYTES - 1);
    if (capture) block_buf <= assembled;
  end

  // Hand-off: the block is published only when it completes without rollback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      finish_sign_to_fetcher <= 1'b0;
      inst_block_to_fetcher  <= '0;
    end else begin
      finish_sign_to_fetcher <= capture_last && !abort;
      if (capture_last && !abort) inst_block_to_fetcher <= assembled;
    end
  end

endmodule

// File: tb/tb_icache_block_responder.sv
// Bench for icache_block_responder: a byte RAM model, a block scoreboard
// and one task per scenario.
module tb_icache_block_responder;

  localparam int BB = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rdy = 1'b1;
  logic         en = 1'b0;
  logic         rb = 1'b0;
  logic         grant = 1'b1;
  logic [31:0]  pc = '0;
  logic         finish;
  logic [127:0] blk;
  logic         bus_req;
  logic [31:0]  mem_a;
  logic [7:0]   mem_din = '0;
  logic         mem_wr;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  logic [127:0] want_q[$];
  logic [31:0]  addr_q[$];
  int           lat, nfin, stray_a;

  always #5 clk = ~clk;

  icache_block_responder dut (
    .clk                        (clk),
    .rst                        (rst),
    .rdy                        (rdy),
    .enable_sign_from_fetcher   (en),
    .pc_from_fetcher            (pc),
    .rollback_sign_from_fetcher (rb),
    .finish_sign_to_fetcher     (finish),
    .inst_block_to_fetcher      (blk),
    .bus_req_to_arbiter         (bus_req),
    .bus_grant_from_arbiter     (grant),
    .mem_a_to_ram               (mem_a),
    .mem_din_from_ram           (mem_din),
    .mem_wr_to_ram              (mem_wr)
  );

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return a[7:0] + {4'h0, a[11:8]};
  endfunction

  always @(posedge clk) mem_din <= ram_byte(mem_a);

  function automatic logic [127:0] model_block(input logic [31:0] b);
    logic [127:0] r;
    for (int k = 0; k < BB; k++) r[8*k +: 8] = ram_byte(b + 32'(k));
    return r;
  endfunction

  // Drives one request and records what the DUT produced; tests judge the records.
  task automatic drive(input logic [31:0] p, input bit expect_blk, input int stall_at,
                       input int stall_len, input bit stall_rdy, input int rb_issue,
                       input bit rb_last, input int ncyc);
    int issued, stalled, cyc;
    bit fired;
    logic [127:0] w;
    issued = 0; stalled = 0; cyc = 0; fired = 0;
    lat = -1; nfin = 0; stray_a = 0;
    addr_q.delete(); got_q.delete(); want_q.delete();
    @(negedge clk);
    en = 1'b1; pc = p; rb = 1'b0; grant = 1'b1; rdy = 1'b1;
    if (expect_blk) exp_q.push_back(model_block({p[31:4], 4'h0}));
    @(posedge clk);
    cyc = 1;
    repeat (ncyc) begin
      @(negedge clk);
      en = 1'b0; grant = 1'b1; rdy = 1'b1; rb = 1'b0;
      if (stall_at >= 0 && issued == stall_at && stalled < stall_len) begin
        if (stall_rdy) rdy = 1'b0;
        else           grant = 1'b0;
        stalled++;
      end
      if (!fired && rb_issue >= 0 && issued == rb_issue) begin rb = 1'b1; fired = 1; end
      if (!fired && rb_last && issued == BB) begin rb = 1'b1; fired = 1; end
      #1;
      if (finish === 1'b1) begin
        nfin++;
        if (lat < 0) lat = cyc;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        got_q.push_back(blk);
        want_q.push_back(w);
      end
      if (bus_req && grant && rdy) begin
        addr_q.push_back(mem_a);
        issued++;
      end else if (mem_a !== 32'h0) begin
        stray_a++;
      end
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (finish !== 1'b0)   begin bad++; $display("FAIL reset_finish: got %b want 0", finish); end
    total++; if (blk !== '0)        begin bad++; $display("FAIL reset_block: got %h want 0", blk); end
    total++; if (bus_req !== 1'b0)  begin bad++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    total++; if (mem_a !== 32'h0)   begin bad++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    total++; if (mem_wr !== 1'b0)   begin bad++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    drive(32'h104, 1, -1, 0, 0, -1, 0, 26);
    total++; if (nfin !== 1) begin bad++; $display("FAIL basic_finish_count: got %0d want 1", nfin); end
    total++; if (lat !== 18) begin bad++; $display("FAIL basic_latency: got %0d want 18", lat); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== want_q[0]) begin
      bad++; $display("FAIL basic_block_sb: got %h want %h", blk, model_block(32'h100));
    end
    total++;
    if (blk !== 128'h100F0E0D0C0B0A090807060504030201) begin
      bad++; $display("FAIL basic_block_const: got %h want 100f0e0d0c0b0a090807060504030201", blk);
    end
    total++; if (addr_q.size() != BB) begin bad++; $display("FAIL basic_issue_count: got %0d want 16", addr_q.size()); end
    for (int k = 0; k < addr_q.size(); k++) begin
      total++;
      if (addr_q[k] !== 32'h100 + 32'(k)) begin
        bad++; $display("FAIL basic_addr%0d: got %h want %h", k, addr_q[k], 32'h100 + 32'(k));
      end
    end
    total++; if (stray_a !== 0) begin bad++; $display("FAIL basic_idle_addr: got %0d nonzero want 0", stray_a); end
  endtask

  task automatic test_stall();
    drive(32'h104, 1, 5, 3, 0, -1, 0, 30);
    total++; if (nfin !== 1) begin bad++; $display("FAIL stall_finish_count: got %0d want 1", nfin); end
    total++; if (lat !== 21) begin bad++; $display("FAIL stall_latency: got %0d want 21", lat); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== 128'h100F0E0D0C0B0A090807060504030201) begin
      bad++; $display("FAIL stall_block: got %h want 100f0e0d0c0b0a090807060504030201", blk);
    end
    total++; if (stray_a !== 0) begin bad++; $display("FAIL stall_mem_a_zero: got %0d nonzero want 0", stray_a); end
    for (int k = 0; k < addr_q.size(); k++) begin
      total++;
      if (addr_q[k] !== 32'h100 + 32'(k)) begin
        bad++; $display("FAIL stall_addr%0d: got %h want %h", k, addr_q[k], 32'h100 + 32'(k));
      end
    end
  endtask

  task automatic test_rollback_mid();
    logic [127:0] prev;
    prev = blk;
    drive(32'h104, 0, -1, 0, 0, 7, 0, 12);
    total++; if (nfin !== 0) begin bad++; $display("FAIL rbmid_finish: got %0d want 0", nfin); end
    total++; if (addr_q.size() != 8) begin bad++; $display("FAIL rbmid_issues: got %0d want 8", addr_q.size()); end
    total++; if (blk !== prev) begin bad++; $display("FAIL rbmid_block_kept: got %h want %h", blk, prev); end
    @(negedge clk);
    en = 1'b1; rb = 1'b1;
    @(negedge clk);
    en = 1'b0; rb = 1'b0;
    #1;
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rb_beats_enable: got bus_req %b want 0", bus_req); end
    drive(32'h200, 1, -1, 0, 0, -1, 0, 26);
    total++; if (nfin !== 1) begin bad++; $display("FAIL rbmid_new_finish: got %0d want 1", nfin); end
    total++; if (lat !== 18) begin bad++; $display("FAIL rbmid_new_latency: got %0d want 18", lat); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== want_q[0]) begin
      bad++; $display("FAIL rbmid_new_block: got %h want %h", blk, model_block(32'h200));
    end
  endtask

  task automatic test_rollback_done();
    logic [127:0] prev;
    prev = blk;
    drive(32'h300, 0, -1, 0, 0, -1, 1, 24);
    total++; if (nfin !== 0) begin bad++; $display("FAIL rbdone_finish: got %0d want 0", nfin); end
    total++; if (blk !== prev) begin bad++; $display("FAIL rbdone_block_kept: got %h want %h", blk, prev); end
    total++; if (addr_q.size() != BB) begin bad++; $display("FAIL rbdone_issues: got %0d want 16", addr_q.size()); end
  endtask

  task automatic test_rdy_stall();
    drive(32'h480, 1, 5, 4, 1, -1, 0, 30);
    total++; if (nfin !== 1) begin bad++; $display("FAIL rdy_finish_count: got %0d want 1", nfin); end
    total++; if (lat !== 22) begin bad++; $display("FAIL rdy_latency: got %0d want 22", lat); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== want_q[0]) begin
      bad++; $display("FAIL rdy_block: got %h want %h", blk, model_block(32'h480));
    end
    total++; if (stray_a !== 0) begin bad++; $display("FAIL rdy_mem_a_zero: got %0d nonzero want 0", stray_a); end
    for (int k = 0; k < addr_q.size(); k++) begin
      total++;
      if (addr_q[k] !== 32'h480 + 32'(k)) begin
        bad++; $display("FAIL rdy_addr%0d: got %h want %h", k, addr_q[k], 32'h480 + 32'(k));
      end
    end
  endtask

  task automatic test_reset_wrap();
    drive(32'h700, 0, -1, 0, 0, -1, 0, 6);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (finish !== 1'b0)  begin bad++; $display("FAIL midrst_finish: got %b want 0", finish); end
    total++; if (blk !== '0)       begin bad++; $display("FAIL midrst_block: got %h want 0", blk); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL midrst_bus_req: got %b want 0", bus_req); end
    total++; if (mem_a !== 32'h0)  begin bad++; $display("FAIL midrst_mem_a: got %h want 0", mem_a); end
    rst = 1'b1;
    drive(32'hFFFF_FFF3, 1, -1, 0, 0, -1, 0, 26);
    total++; if (nfin !== 1) begin bad++; $display("FAIL wrap_finish_count: got %0d want 1", nfin); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== want_q[0]) begin
      bad++; $display("FAIL wrap_block: got %h want %h", blk, model_block(32'hFFFF_FFF0));
    end
    total++; if (addr_q.size() != BB) begin bad++; $display("FAIL wrap_issues: got %0d want 16", addr_q.size()); end
    for (int k = 0; k < addr_q.size(); k++) begin
      total++;
      if (addr_q[k] !== 32'hFFFF_FFF0 + 32'(k)) begin
        bad++; $display("FAIL wrap_addr%0d: got %h want %h", k, addr_q[k], 32'hFFFF_FFF0 + 32'(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_rollback_mid();
    test_rollback_done();
    test_rdy_stall();
    test_reset_wrap();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
